// File: rtl/inst_fetcher_pkg.sv
// eei: shared execution-environment types for the fetch path.
//   XLEN/ILEN  - address and instruction widths
//   Addr/Inst  - address and instruction words
//   FetchState - inst_fetcher FSM state
//   FetchEntry - one buffered instruction with its PC
package eei;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] Addr;
  typedef logic [ILEN-1:0] Inst;

  // S_IDLE: nothing outstanding; S_WAIT: response pending;
  // S_DROP: response pending but stale (a flush overtook it).
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} FetchState;

  typedef struct packed {
    Addr pc;
    Inst bits;
  } FetchEntry;
endpackage

// File: rtl/inst_fetcher_if.sv
// i_membus: instruction-side memory request/response channel.
//   mem_valid/mem_ready/mem_addr  - request handshake (fetcher -> arbiter)
//   mem_rvalid/mem_rdata          - response, one per accepted request
// master = fetcher side, slave = memory/arbiter side.
interface inst_fetcher_if;
  logic     mem_valid;
  logic     mem_ready;
  eei::Addr mem_addr;
  logic     mem_rvalid;
  eei::Inst mem_rdata;

  modport master (output mem_valid, mem_addr, input mem_ready, mem_rvalid, mem_rdata);
  modport slave  (input mem_valid, mem_addr, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/inst_fetcher_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two DEPTH.
//   clk, rst (sync, active high), clear (sync flush of contents)
//   push/push_data, pop, count (0..DEPTH), head (valid when count != 0)
// Push and pop in the same cycle are legal even when full: the write lands
// in the slot being vacated by the pop.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // storage is zeroed so the head reads 0 out of reset
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: sequential instruction prefetch with one request in flight.
//   clk, rst          - clock, synchronous active-high reset
//   flush, flush_pc   - redirect; clears buffered/in-flight work
//   bus (master)      - i_membus request/response
//   inst_valid/ready  - head-of-queue handshake to decode
//   inst_pc/inst_bits - head entry
// Build option: INST_FETCHER_BYPASS_EN - when the queue is empty a response
// arriving in S_WAIT is presented on inst_* in the same cycle.
module inst_fetcher import eei::*; #(
  parameter int  FIFO_DEPTH = 4,
  parameter Addr INIT_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  Addr                   flush_pc,
  inst_fetcher_if.master        bus,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output Addr                   inst_pc,
  output Inst                   inst_bits
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  FetchState          state;
  Addr                fetch_pc, req_pc;
  logic [CW-1:0]      count;
  logic [$bits(FetchEntry)-1:0] head_raw;
  FetchEntry          head;
  logic               fifo_ne, rsp_hit, push, pop;

  assign head    = head_raw;
  assign fifo_ne = (count != '0);
  assign rsp_hit = !rst && (state == S_WAIT) && bus.mem_rvalid;

  // mem_valid has to drop in the flush cycle itself, so it is decoded from
  // the registered state rather than registered on its own.
  assign bus.mem_valid = !rst && (state == S_IDLE) && (count < CW'(FIFO_DEPTH)) && !flush;
  assign bus.mem_addr  = fetch_pc;

`ifdef INST_FETCHER_BYPASS_EN
  logic bypass;
  assign bypass = rsp_hit && !fifo_ne;
  always_comb begin
    inst_valid = bypass ? !flush : fifo_ne;
    inst_pc    = bypass ? req_pc : head.pc;
    inst_bits  = bypass ? bus.mem_rdata : head.bits;
  end
  // a bypassed entry consumed on the spot never enters the queue
  assign push = rsp_hit && !flush && !(bypass && inst_ready);
`else
  always_comb begin
    inst_valid = fifo_ne;
    inst_pc    = head.pc;
    inst_bits  = head.bits;
  end
  assign push = rsp_hit && !flush;
`endif

  assign pop = inst_valid && inst_ready && fifo_ne;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= INIT_PC;
      req_pc   <= '0;
    end else if (flush) begin
      fetch_pc <= flush_pc;
      // a response landing in the flush cycle retires the stale request
      state    <= (state != S_IDLE && !bus.mem_rvalid) ? S_DROP : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.mem_valid && bus.mem_ready) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + Addr'(4);
          state    <= S_WAIT;
        end
        S_WAIT, S_DROP: if (bus.mem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH($bits(FetchEntry)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({req_pc, bus.mem_rdata}),
    .pop       (pop),
    .count     (count),
    .head      (head_raw)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!rst) assert (!(state == S_IDLE && bus.mem_rvalid))
      else $error("inst_fetcher: mem_rvalid with no request outstanding");
`endif
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios followed by a randomized run.
// The reference is the architectural instruction stream: decode must see
// consecutive PCs from the last reset/redirect target, each carrying the
// memory word for that PC; requests must go out in the same order, one at
// a time.
module tb_inst_fetcher;
  import eei::*;

  localparam int  DEPTH = 4;
  localparam Addr INIT  = 64'h1000;
`ifdef INST_FETCHER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, inst_ready = 1'b0;
  Addr  flush_pc = '0;
  logic inst_valid;
  Addr  inst_pc;
  Inst  inst_bits;

  inst_fetcher_if bus ();

  inst_fetcher #(.FIFO_DEPTH(DEPTH), .INIT_PC(INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .bus        (bus),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_pc    (inst_pc),
    .inst_bits  (inst_bits)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic Inst mem_word(input Addr a);
    return ~a[31:0] ^ a[63:32] ^ 32'h3C00_00A5;
  endfunction

  // memory model + stream reference
  bit   outst = 0;
  int   wait_cnt = 0;
  Addr  resp_addr = '0;
  Addr  exp_pc = INIT, exp_issue = INIT;
  int   n_acc = 0, n_cons = 0;
  bit   prev_flush = 0;
  Addr  cons_log[$];
  Addr  acc_log[$];

  // directed knobs (used when rnd == 0)
  bit   rnd = 0, k_flush = 0, k_mready = 0, k_iready = 0;
  Addr  k_flush_pc = '0;
  int   k_lat = 1;

  task automatic cyc();
    @(posedge clk); #1;
    bus.mem_rvalid = outst && (wait_cnt == 1);
    bus.mem_rdata  = bus.mem_rvalid ? mem_word(resp_addr) : Inst'($urandom);
    if (rnd) begin
      flush         = ($urandom_range(0, 19) == 0);
      flush_pc      = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                  : {32'h0, $urandom & 32'hFFFF_FFFC};
      bus.mem_ready = ($urandom_range(0, 9) < 7);
      inst_ready    = ($urandom_range(0, 3) != 0);
    end else begin
      flush         = k_flush;
      flush_pc      = k_flush_pc;
      bus.mem_ready = k_mready;
      inst_ready    = k_iready;
    end
    @(negedge clk);
    if (prev_flush) chk("post_flush_iv", inst_valid, 0);
    chk("single_outst", bus.mem_valid && outst, 0);
    if (flush) chk("flush_mv", bus.mem_valid, 0);
    if (inst_valid && inst_ready) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_bits", inst_bits, mem_word(exp_pc));
      cons_log.push_back(inst_pc);
      n_cons++;
      exp_pc += 4;
    end
    if (outst) begin
      if (bus.mem_rvalid) outst = 0;
      else wait_cnt--;
    end
    if (bus.mem_valid && bus.mem_ready) begin
      chk("mem_addr", bus.mem_addr, exp_issue);
      acc_log.push_back(bus.mem_addr);
      n_acc++;
      exp_issue += 4;
      outst     = 1;
      resp_addr = bus.mem_addr;
      wait_cnt  = rnd ? $urandom_range(1, 3) : k_lat;
    end
    if (flush) begin
      exp_pc    = flush_pc;
      exp_issue = flush_pc;
    end
    prev_flush = flush;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; flush = 0; inst_ready = 0;
    bus.mem_rvalid = 0; bus.mem_ready = 0;
    outst = 0; rnd = 0; k_flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, INIT);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_bits", inst_bits, 0);
    exp_pc = INIT; exp_issue = INIT; prev_flush = 0;
    n_acc = 0; n_cons = 0;
    cons_log.delete(); acc_log.delete();
    rst = 0;
  endtask

  initial begin
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    // sequential fetch, 1-cycle memory, and response-to-visible latency
    do_reset();
    k_mready = 1; k_iready = 1; k_lat = 1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 1) begin
        chk("lat_rvalid", bus.mem_rvalid, 1);
        chk("lat_iv_same", inst_valid, BYP);
      end
      if (i == 2) chk("lat_iv_next", inst_valid, !BYP);
    end
    chk("tput_cons", n_cons, BYP ? 6 : 5);
    chk("seq_pc2", (cons_log.size() >= 3) ? cons_log[2] : '1, 64'h1008);

    // back-pressure: queue fills, fetch stops, then drains in order
    do_reset();
    k_mready = 1; k_iready = 0; k_lat = 1;
    repeat (20) cyc();
    chk("full_acc", n_acc, DEPTH);
    chk("full_mv", bus.mem_valid, 0);
    k_iready = 1;
    repeat (20) cyc();
    chk("drain_pc3", (cons_log.size() >= 4) ? cons_log[3] : '1, 64'h100C);
    chk("resume_addr", (acc_log.size() >= 5) ? acc_log[4] : '1, 64'h1010);

    // flush while waiting on a 3-cycle response
    do_reset();
    k_mready = 1; k_iready = 1; k_lat = 3;
    cyc();
    chk("wait_acc", n_acc, 1);
    k_flush = 1; k_flush_pc = 64'h2000;
    cyc();
    k_flush = 0;
    cons_log.delete();
    cyc();
    chk("drop_mv", bus.mem_valid, 0);
    repeat (15) cyc();
    chk("flush_wait_pc", (cons_log.size() > 0) ? cons_log[0] : '1, 64'h2000);

    // flush coinciding with a response and a pop
    do_reset();
    k_mready = 1; k_iready = 0; k_lat = 1;
    for (int i = 0; i < 20 && n_acc < 4; i++) cyc();
    chk("fill_acc", n_acc, 4);
    k_flush = 1; k_flush_pc = 64'h2000; k_iready = 1;
    cyc();
    chk("coinc_rvalid", bus.mem_rvalid, 1);
    chk("coinc_pop", inst_valid, 1);
    k_flush = 0; k_iready = 0;
    cons_log.delete();
    cyc();
    chk("coinc_mv", bus.mem_valid, 1);
    chk("coinc_addr", bus.mem_addr, 64'h2000);
    k_iready = 1;
    repeat (10) cyc();
    chk("coinc_first", (cons_log.size() > 0) ? cons_log[0] : '1, 64'h2000);

    // request held off by the arbiter
    do_reset();
    k_mready = 0; k_iready = 1; k_lat = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_mv", bus.mem_valid, 1);
      chk("stall_addr", bus.mem_addr, INIT);
    end
    k_mready = 1;
    cyc();
    chk("stall_acc", n_acc, 1);
    repeat (6) cyc();

    // randomized traffic against the stream reference
    do_reset();
    rnd = 1;
    repeat (3000) cyc();
    rnd = 0;
    chk("rand_progress", n_cons > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
